// File: rtl/vec_alu_pkg.sv
// Shared types and defaults for the pipelined vector ALU.
// The op_e encoding matches the 3-bit opcode from the vector register read stage.
package vec_alu_pkg;

    localparam int unsigned DefN = 16;
    localparam int unsigned DefV = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRA = 3'b110,
        OP_DUP = 3'b111
    } op_e;

    typedef logic [DefV-1:0][DefN-1:0] vec_t;

    // DUP partner: lanes are swapped in adjacent pairs (0<->1, 2<->3, ...).
    function automatic int unsigned pair_lane(input int unsigned lane);
        return lane ^ 32'd1;
    endfunction

endpackage

// File: rtl/vec_alu_if.sv
// Operand/result handshake bundle between the register read stage and the vector ALU.
// master = producer/consumer side, slave = ALU side.
interface vec_alu_if
    import vec_alu_pkg::*;
#(
    parameter int unsigned N = DefN,
    parameter int unsigned V = DefV
);
    logic                  in_valid;
    logic                  in_ready;
    op_e                   op;
    logic                  sat;
    logic [V-1:0]          mask;
    logic [V-1:0][N-1:0]   a;
    logic [V-1:0][N-1:0]   b;
    logic                  out_valid;
    logic                  out_ready;
    logic [V-1:0][N-1:0]   result;
    logic [V-1:0]          zero;

    modport master (
        output in_valid, op, sat, mask, a, b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op, sat, mask, a, b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/vec_alu_lane.sv
// Combinational single-lane compute: arithmetic with optional signed saturation, logic, shifts.
// DUP is handled at vector level; this lane just returns a for it.
module vec_alu_lane
    import vec_alu_pkg::*;
#(
    parameter int unsigned N = DefN
) (
    input  op_e          op_i,
    input  logic         sat_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] y_o
);
    localparam int unsigned SHW = $clog2(N);

    localparam logic [N-1:0] SMax = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SMin = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0]   sum;
    logic [N-1:0]   diff;
    logic           add_ovf;
    logic           sub_ovf;
    logic [N-1:0]   clamp;
    logic [SHW-1:0] shamt;

    always_comb begin
        sum   = a_i + b_i;
        diff  = a_i - b_i;
        // Signed overflow: result sign differs from the sign the true result must have.
        add_ovf = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
        sub_ovf = (a_i[N-1] != b_i[N-1]) && (diff[N-1] != a_i[N-1]);
        clamp = a_i[N-1] ? SMin : SMax;
        shamt = b_i[SHW-1:0];

        y_o = '0;
        unique case (op_i)
            OP_ADD:  y_o = (sat_i && add_ovf) ? clamp : sum;
            OP_SUB:  y_o = (sat_i && sub_ovf) ? clamp : diff;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_SLL:  y_o = a_i << shamt;
            OP_SRA:  y_o = N'($signed(a_i) >>> shamt);
            OP_DUP:  y_o = a_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/vec_alu_pipe.sv
// Two-stage vector ALU: S1 registers operands, S2 registers masked lane results and zero flags.
// Valid/ready backpressure with full throughput; S1 advances whenever S2 is empty or draining.
module vec_alu_pipe
    import vec_alu_pkg::*;
#(
    parameter int unsigned N = DefN,
    parameter int unsigned V = DefV
) (
    input  logic      clk,
    input  logic      rst_n,
    vec_alu_if.slave  bus
);
    logic                s1_valid_q, s1_valid_d;
    op_e                 s1_op_q, s1_op_d;
    logic                s1_sat_q, s1_sat_d;
    logic [V-1:0]        s1_mask_q, s1_mask_d;
    logic [V-1:0][N-1:0] s1_a_q, s1_a_d;
    logic [V-1:0][N-1:0] s1_b_q, s1_b_d;

    logic                s2_valid_q, s2_valid_d;
    logic [V-1:0][N-1:0] result_q, result_d;
    logic [V-1:0]        zero_q, zero_d;

    logic [V-1:0][N-1:0] lane_y;
    logic [V-1:0][N-1:0] lane_res;
    logic [V-1:0]        lane_zero;

    logic s2_adv;
    logic in_ready;
    logic accept;

    for (genvar i = 0; i < V; i++) begin : g_lane
        localparam int unsigned Pair = pair_lane(i);

        vec_alu_lane #(
            .N (N)
        ) u_lane (
            .op_i  (s1_op_q),
            .sat_i (s1_sat_q),
            .a_i   (s1_a_q[i]),
            .b_i   (s1_b_q[i]),
            .y_o   (lane_y[i])
        );

        // Masked-off lanes pass a through untouched, including under DUP.
        assign lane_res[i]  = !s1_mask_q[i]       ? s1_a_q[i]    :
                              (s1_op_q == OP_DUP) ? s1_a_q[Pair] : lane_y[i];
        assign lane_zero[i] = (lane_res[i] == '0);
    end

    always_comb begin
        s2_adv   = !s2_valid_q || bus.out_ready;
        in_ready = !s1_valid_q || s2_adv;
        accept   = bus.in_valid && in_ready;

        s1_op_d   = s1_op_q;
        s1_sat_d  = s1_sat_q;
        s1_mask_d = s1_mask_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        if (accept) begin
            s1_op_d   = bus.op;
            s1_sat_d  = bus.sat;
            s1_mask_d = bus.mask;
            s1_a_d    = bus.a;
            s1_b_d    = bus.b;
        end
        // When S2 is stuck, in_ready implies S1 was empty, so accept never overwrites.
        s1_valid_d = accept || (s1_valid_q && !s2_adv);

        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        result_d   = result_q;
        zero_d     = zero_q;
        if (s2_adv && s1_valid_q) begin
            result_d = lane_res;
            zero_d   = lane_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_ADD;
            s1_sat_q   <= 1'b0;
            s1_mask_q  <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_sat_q   <= s1_sat_d;
            s1_mask_q  <= s1_mask_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

endmodule
